// File: rtl/sar_conv_scheduler.sv
// Shares one SAR ADC core among NCH requesters: round-robin grant, mux settling,
// start pulse, bounded wait for done, and a valid/ready result with channel tag.
module sar_conv_scheduler #(
    parameter int NCH            = 4,
    parameter int CHW            = 2,
    parameter int DW             = 8,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic           i_clk,
    input  logic           i_reset_n,
    input  logic [NCH-1:0] i_req,
    output logic [NCH-1:0] o_grant,
    output logic [CHW-1:0] o_muxsel,
    output logic           o_sar_start,
    input  logic           i_sar_done,
    input  logic [DW-1:0]  i_sar_data,
    output logic [DW-1:0]  o_result_data,
    output logic [CHW-1:0] o_result_ch,
    output logic           o_result_valid,
    input  logic           i_result_ready,
    output logic           o_timeout_err,
    input  logic           i_err_clr
);

    localparam int CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
    localparam int CNTW    = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_START,
        S_CONVERT,
        S_DELIVER
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [NCH-1:0] r_grant;
    logic [NCH-1:0] w_grant_nxt;
    logic [CHW-1:0] r_muxsel;
    logic [CHW-1:0] w_muxsel_nxt;
    logic           r_sar_start;
    logic           w_sar_start_nxt;
    logic [DW-1:0]  r_result_data;
    logic [DW-1:0]  w_result_data_nxt;
    logic [CHW-1:0] r_result_ch;
    logic [CHW-1:0] w_result_ch_nxt;
    logic           r_result_valid;
    logic           w_result_valid_nxt;
    logic           r_timeout_err;
    logic           w_timeout_err_nxt;
    logic [CHW-1:0] r_ptr;
    logic [CHW-1:0] w_ptr_nxt;
    logic [CNTW-1:0] r_cnt;
    logic [CNTW-1:0] w_cnt_nxt;

    logic           w_found;
    logic [CHW-1:0] w_sel;
    logic [CHW:0]   w_sum;
    logic           w_timeout;

    // Round-robin search: walk upward from the pointer, wrapping past NCH-1.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_sum   = '0;
        for (int j = 0; j < NCH; j++) begin
            w_sum = {1'b0, r_ptr} + (CHW+1)'(j);
            if (w_sum >= (CHW+1)'(NCH)) begin
                w_sum = w_sum - (CHW+1)'(NCH);
            end
            if (!w_found && i_req[w_sum[CHW-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_sum[CHW-1:0];
            end
        end
    end

    always_comb begin
        w_state_nxt        = r_state;
        w_grant_nxt        = r_grant;
        w_muxsel_nxt       = r_muxsel;
        w_sar_start_nxt    = 1'b0;
        w_result_data_nxt  = r_result_data;
        w_result_ch_nxt    = r_result_ch;
        w_result_valid_nxt = r_result_valid;
        w_ptr_nxt          = r_ptr;
        w_cnt_nxt          = r_cnt;
        w_timeout          = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_grant_nxt = '0;
                if (w_found) begin
                    w_grant_nxt  = {{(NCH-1){1'b0}}, 1'b1} << w_sel;
                    w_muxsel_nxt = w_sel;
                    w_ptr_nxt    = (w_sel == CHW'(NCH-1)) ? '0 : w_sel + 1'b1;
                    w_cnt_nxt    = CNTW'(SETTLE_CYCLES - 1);
                    w_state_nxt  = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (r_cnt == '0) begin
                    w_sar_start_nxt = 1'b1;
                    w_state_nxt     = S_START;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_START: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_CONVERT;
            end
            S_CONVERT: begin
                if (i_sar_done) begin
                    w_result_data_nxt  = i_sar_data;
                    w_result_ch_nxt    = r_muxsel;
                    w_result_valid_nxt = 1'b1;
                    w_state_nxt        = S_DELIVER;
                end else if (r_cnt == CNTW'(TIMEOUT_CYCLES - 1)) begin
                    // Abandon the conversion; nothing is delivered for this grant.
                    w_timeout   = 1'b1;
                    w_grant_nxt = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_DELIVER: begin
                if (r_result_valid && i_result_ready) begin
                    w_result_valid_nxt = 1'b0;
                    w_grant_nxt        = '0;
                    w_state_nxt        = S_IDLE;
                end
            end
            default: begin
                w_grant_nxt = '0;
                w_state_nxt = S_IDLE;
            end
        endcase

        // A timeout coinciding with a clear leaves the flag set.
        if (w_timeout) begin
            w_timeout_err_nxt = 1'b1;
        end else if (i_err_clr) begin
            w_timeout_err_nxt = 1'b0;
        end else begin
            w_timeout_err_nxt = r_timeout_err;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state        <= S_IDLE;
            r_grant        <= '0;
            r_muxsel       <= '0;
            r_sar_start    <= 1'b0;
            r_result_data  <= '0;
            r_result_ch    <= '0;
            r_result_valid <= 1'b0;
            r_timeout_err  <= 1'b0;
            r_ptr          <= '0;
            r_cnt          <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_grant        <= w_grant_nxt;
            r_muxsel       <= w_muxsel_nxt;
            r_sar_start    <= w_sar_start_nxt;
            r_result_data  <= w_result_data_nxt;
            r_result_ch    <= w_result_ch_nxt;
            r_result_valid <= w_result_valid_nxt;
            r_timeout_err  <= w_timeout_err_nxt;
            r_ptr          <= w_ptr_nxt;
            r_cnt          <= w_cnt_nxt;
        end
    end

    assign o_grant        = r_grant;
    assign o_muxsel       = r_muxsel;
    assign o_sar_start    = r_sar_start;
    assign o_result_data  = r_result_data;
    assign o_result_ch    = r_result_ch;
    assign o_result_valid = r_result_valid;
    assign o_timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_sar_conv_scheduler.sv
// Self-checking bench for sar_conv_scheduler: table of arbitration vectors,
// hand-written corner sequences and random transactions against a transaction model.
module tb_sar_conv_scheduler;

    localparam int NCH    = 4;
    localparam int CHW    = 2;
    localparam int DW     = 8;
    localparam int SETTLE = 4;
    localparam int TO     = 16;

    logic           clk = 1'b0;
    logic           i_reset_n;
    logic [NCH-1:0] i_req;
    logic [NCH-1:0] o_grant;
    logic [CHW-1:0] o_muxsel;
    logic           o_sar_start;
    logic           i_sar_done;
    logic [DW-1:0]  i_sar_data;
    logic [DW-1:0]  o_result_data;
    logic [CHW-1:0] o_result_ch;
    logic           o_result_valid;
    logic           i_result_ready;
    logic           o_timeout_err;
    logic           i_err_clr;

    always #5 clk = ~clk;

    sar_conv_scheduler #(
        .NCH(NCH), .CHW(CHW), .DW(DW),
        .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_clk(clk),
        .i_reset_n(i_reset_n),
        .i_req(i_req),
        .o_grant(o_grant),
        .o_muxsel(o_muxsel),
        .o_sar_start(o_sar_start),
        .i_sar_done(i_sar_done),
        .i_sar_data(i_sar_data),
        .o_result_data(o_result_data),
        .o_result_ch(o_result_ch),
        .o_result_valid(o_result_valid),
        .i_result_ready(i_result_ready),
        .o_timeout_err(o_timeout_err),
        .i_err_clr(i_err_clr)
    );

    typedef struct {
        logic [NCH-1:0] req;
        logic [DW-1:0]  data;
        int             done_dly;
        int             rdy_dly;
        int             exp_ch;
    } vec_t;

    vec_t tbl [8];

    int   n_checks = 0;
    int   n_err    = 0;
    int   m_ptr    = 0;
    logic m_err    = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference arbitration: first requester at or above the pointer, with wrap.
    function automatic int rr_pick(input logic [NCH-1:0] req, input int ptr);
        int c;
        for (int i = 0; i < NCH; i++) begin
            c = (ptr + i) % NCH;
            if (req[c]) return c;
        end
        return -1;
    endfunction

    task automatic drive_req(input int hold, input logic [NCH-1:0] req);
        if (hold == 0)      i_req = '0;
        else if (hold == 1) i_req = req;
        else                i_req = NCH'($urandom_range(0, (1 << NCH) - 1));
    endtask

    // One full transaction starting in an IDLE cycle and ending in the next IDLE cycle.
    task automatic conv(input logic [NCH-1:0] req, input int hold, input logic [DW-1:0] data,
                        input int done_dly, input int rdy_dly, input int exp_ch,
                        input bit clr_at_to, input bit noise);
        logic [NCH-1:0] g;
        bit got;
        g   = NCH'(1 << exp_ch);
        got = 1'b0;
        i_req = req;
        tick();
        check("grant", 32'(o_grant), 32'(g));
        check("muxsel", 32'(o_muxsel), exp_ch);
        check("start_at_grant", 32'(o_sar_start), 0);
        m_ptr = (exp_ch + 1) % NCH;
        for (int s = 1; s < SETTLE; s++) begin
            drive_req(hold, req);
            if (noise) begin
                i_sar_done = 1'($urandom_range(0, 1));
                i_sar_data = DW'($urandom);
            end
            tick();
            check("settle_start", 32'(o_sar_start), 0);
            check("settle_grant", 32'(o_grant), 32'(g));
        end
        drive_req(hold, req);
        if (noise) i_sar_done = 1'($urandom_range(0, 1));
        tick();
        check("start_pulse", 32'(o_sar_start), 1);
        check("start_muxsel", 32'(o_muxsel), exp_ch);
        for (int i = 0; i < TO; i++) begin
            drive_req(hold, req);
            i_sar_done = 1'b0;
            tick();
            check("conv_start", 32'(o_sar_start), 0);
            check("conv_valid", 32'(o_result_valid), 0);
            check("conv_grant", 32'(o_grant), 32'(g));
            if (i == done_dly) begin
                i_sar_done = 1'b1;
                i_sar_data = data;
                got = 1'b1;
                break;
            end
            if (i == TO - 1 && clr_at_to) i_err_clr = 1'b1;
        end
        if (got) begin
            drive_req(hold, req);
            tick();
            i_sar_done = 1'b0;
            i_sar_data = ~data;
            for (int k = 0; k <= rdy_dly; k++) begin
                check("dlv_valid", 32'(o_result_valid), 1);
                check("dlv_data", 32'(o_result_data), 32'(data));
                check("dlv_ch", 32'(o_result_ch), exp_ch);
                check("dlv_grant", 32'(o_grant), 32'(g));
                check("dlv_start", 32'(o_sar_start), 0);
                i_result_ready = (k == rdy_dly);
                drive_req(hold, req);
                tick();
            end
            check("post_valid", 32'(o_result_valid), 0);
            check("post_grant", 32'(o_grant), 0);
            check("post_err", 32'(o_timeout_err), 32'(m_err));
            i_result_ready = 1'b1;
        end else begin
            drive_req(hold, req);
            tick();
            i_err_clr = 1'b0;
            m_err = 1'b1;
            check("to_err", 32'(o_timeout_err), 1);
            check("to_grant", 32'(o_grant), 0);
            check("to_valid", 32'(o_result_valid), 0);
        end
    endtask

    task automatic clr_err();
        i_req     = '0;
        i_err_clr = 1'b1;
        tick();
        i_err_clr = 1'b0;
        m_err     = 1'b0;
        check("err_clr", 32'(o_timeout_err), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{4'b1111, 8'h10, 2, 0, 0};
        tbl[1] = '{4'b1111, 8'h21, 2, 0, 1};
        tbl[2] = '{4'b1111, 8'h32, 2, 0, 2};
        tbl[3] = '{4'b1111, 8'h43, 2, 0, 3};
        tbl[4] = '{4'b1111, 8'h54, 2, 0, 0};
        tbl[5] = '{4'b0101, 8'h65, 2, 0, 2};
        tbl[6] = '{4'b0101, 8'h76, 2, 0, 0};
        tbl[7] = '{4'b0101, 8'h87, 2, 0, 2};

        i_reset_n      = 1'b0;
        i_req          = '0;
        i_sar_done     = 1'b0;
        i_sar_data     = '0;
        i_result_ready = 1'b1;
        i_err_clr      = 1'b0;
        tick();
        tick();
        check("rst_grant", 32'(o_grant), 0);
        check("rst_muxsel", 32'(o_muxsel), 0);
        check("rst_start", 32'(o_sar_start), 0);
        check("rst_valid", 32'(o_result_valid), 0);
        check("rst_data", 32'(o_result_data), 0);
        check("rst_ch", 32'(o_result_ch), 0);
        check("rst_err", 32'(o_timeout_err), 0);
        i_reset_n = 1'b1;
        tick();
        check("idle_grant", 32'(o_grant), 0);

        // Round-robin order with all requesting, then a sparse pattern
        for (int v = 0; v < 8; v++) begin
            conv(tbl[v].req, 1, tbl[v].data, tbl[v].done_dly, tbl[v].rdy_dly, tbl[v].exp_ch, 1'b0, 1'b0);
        end

        // Basic latency: done in the fifth CONVERT cycle
        conv(4'b0001, 1, 8'hA5, 4, 0, 0, 1'b0, 1'b0);

        // Backpressure for 10 cycles, then the next requester after one IDLE cycle
        conv(4'b1111, 1, 8'h3C, 2, 10, 1, 1'b0, 1'b0);
        conv(4'b1111, 1, 8'hC3, 2, 0, 2, 1'b0, 1'b0);

        // Timeout, normal service afterwards, clear, and timeout racing a clear
        conv(4'b1000, 1, 8'h00, 99, 0, 3, 1'b0, 1'b0);
        conv(4'b0001, 1, 8'h11, 1, 0, 0, 1'b0, 1'b0);
        clr_err();
        conv(4'b0010, 1, 8'h00, 99, 0, 1, 1'b1, 1'b0);

        // Request held for a single cycle only
        conv(4'b0010, 0, 8'h5A, 3, 0, 1, 1'b0, 1'b0);

        // Reset in the middle of a conversion on channel 2
        i_req = 4'b0100;
        tick();
        check("rst5_grant", 32'(o_grant), 32'(4'b0100));
        i_req = '0;
        repeat (SETTLE + 2) tick();
        i_reset_n = 1'b0;
        tick();
        i_reset_n = 1'b1;
        m_ptr = 0;
        m_err = 1'b0;
        check("mid_rst_grant", 32'(o_grant), 0);
        check("mid_rst_muxsel", 32'(o_muxsel), 0);
        check("mid_rst_start", 32'(o_sar_start), 0);
        check("mid_rst_valid", 32'(o_result_valid), 0);
        check("mid_rst_data", 32'(o_result_data), 0);
        check("mid_rst_ch", 32'(o_result_ch), 0);
        check("mid_rst_err", 32'(o_timeout_err), 0);
        i_sar_done = 1'b1;
        i_sar_data = 8'hFF;
        tick();
        i_sar_done = 1'b0;
        check("late_done_valid", 32'(o_result_valid), 0);
        tick();
        check("late_done_valid2", 32'(o_result_valid), 0);
        conv(4'b1111, 1, 8'h77, 2, 1, 0, 1'b0, 1'b0);

        // Random transactions against the model
        for (int t = 0; t < 40; t++) begin
            logic [NCH-1:0] rq;
            int ch;
            int dd;
            int gap;
            gap = $urandom_range(0, 2);
            for (int q = 0; q < gap; q++) begin
                i_req = '0;
                tick();
                check("rnd_idle_grant", 32'(o_grant), 0);
            end
            rq = NCH'($urandom_range(1, (1 << NCH) - 1));
            ch = rr_pick(rq, m_ptr);
            dd = ($urandom_range(0, 7) == 0) ? TO + 1 : $urandom_range(0, TO - 1);
            conv(rq, $urandom_range(0, 2), DW'($urandom), dd, $urandom_range(0, 3), ch,
                 1'($urandom_range(0, 1)), 1'b1);
            if ($urandom_range(0, 3) == 0) clr_err();
            check("rnd_err", 32'(o_timeout_err), 32'(m_err));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
